// File: rtl/instr_prefetch_unit.sv
// rtl/instr_prefetch_unit.sv - variable-latency instruction fetch with prefetch FIFO and jump redirect
module instr_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        stall,
  output logic        bus_start,
  output logic [31:0] bus_addr,
  input  logic [31:0] bus_q,
  input  logic        bus_done,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out,
  output logic        valid_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   bus_addr_q;
  logic          discard_q;

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc4_mem_q   [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          empty, full;
  logic          issue, push, pop;
  logic [31:0]   fetch_pc_inc;

  assign fetch_pc_inc = fetch_pc_q + 32'd4;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));

  // The request strobe is decoded from state: a jump in the same cycle must suppress it.
  assign issue = reset && (state_q == S_IDLE) && !jump && !full;
  assign pop   = !jump && !empty && !stall;
  assign push  = !jump && (state_q == S_WAIT) && bus_done && !discard_q && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (jump) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // bus_addr_q mirrors fetch_pc_q in IDLE and is frozen while a request is outstanding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      bus_addr_q <= RESET_PC;
      discard_q  <= 1'b0;
    end else if (jump) begin
      fetch_pc_q <= jump_addr;
      if ((state_q == S_WAIT) && !bus_done) begin
        discard_q <= 1'b1;
      end else begin
        state_q    <= S_IDLE;
        discard_q  <= 1'b0;
        bus_addr_q <= jump_addr;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus_done) begin
            state_q   <= S_IDLE;
            discard_q <= 1'b0;
            if (!discard_q) begin
              fetch_pc_q <= fetch_pc_inc;
              bus_addr_q <= fetch_pc_inc;
            end else begin
              bus_addr_q <= fetch_pc_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= bus_q;
      pc4_mem_q[wr_ptr_q]   <= fetch_pc_inc;
    end
  end

  assign bus_start = issue;
  assign bus_addr  = bus_addr_q;
  assign valid_out = !empty;
  assign instr_out = empty ? 32'd0 : instr_mem_q[rd_ptr_q];
  assign pc4_out   = empty ? 32'd0 : pc4_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// tb/tb_instr_prefetch_unit.sv - randomized bench with queue-based reference model of instr_prefetch_unit
module tb_instr_prefetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'd0;

  logic        clk = 1'b0;
  logic        reset, jump, stall, bus_done, bus_start, valid_out;
  logic [31:0] jump_addr, bus_q, bus_addr, instr_out, pc4_out;

  always #5 clk = ~clk;

  instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .jump      (jump),
    .jump_addr (jump_addr),
    .stall     (stall),
    .bus_start (bus_start),
    .bus_addr  (bus_addr),
    .bus_q     (bus_q),
    .bus_done  (bus_done),
    .instr_out (instr_out),
    .pc4_out   (pc4_out),
    .valid_out (valid_out)
  );

  int n_vec = 0;
  int n_err = 0;

  // stimulus knobs
  int          lat_min = 1, lat_max = 1, stall_pct = 0, jump_pct = 0, stray_pct = 0;
  bit          rst_knob = 1'b0;
  bit          force_jump = 1'b0, force_stray = 1'b0, jump_on_done = 1'b0, jod_fired = 1'b0;
  logic [31:0] force_addr = 32'd0;
  bit          run = 1'b0;

  // reference model: outstanding request + queue of {instr, pc4}
  bit          m_busy, m_drop;
  logic [31:0] m_fetch_pc, m_req_addr;
  int          m_cnt, m_pushes;
  logic [63:0] m_fifo [$];

  int          c_sz;
  bit          c_start;
  logic [63:0] c_head;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy     = 1'b0;
    m_drop     = 1'b0;
    m_fetch_pc = RESET_PC;
    m_req_addr = RESET_PC;
    m_cnt      = 0;
    m_fifo.delete();
  endtask

  // compare DUT against model, then advance model across the coming edge
  always @(negedge clk) begin
    if (run) begin
      c_sz    = m_fifo.size();
      c_head  = (c_sz > 0) ? m_fifo[0] : 64'd0;
      c_start = reset && !m_busy && !jump && (c_sz < DEPTH);
      check("valid_out", 32'(valid_out), 32'(c_sz > 0));
      check("instr_out", instr_out, c_head[63:32]);
      check("pc4_out", pc4_out, c_head[31:0]);
      check("bus_start", 32'(bus_start), 32'(c_start));
      if (!reset || c_start || m_busy)
        check("bus_addr", bus_addr, m_busy ? m_req_addr : m_fetch_pc);
      if (!reset) begin
        model_reset();
      end else if (jump) begin
        m_fifo.delete();
        m_fetch_pc = jump_addr;
        if (m_busy) begin
          if (bus_done) begin
            m_busy = 1'b0;
            m_drop = 1'b0;
          end else begin
            m_drop = 1'b1;
          end
        end
      end else begin
        if (c_sz > 0 && !stall) void'(m_fifo.pop_front());
        if (m_busy && bus_done) begin
          m_busy = 1'b0;
          if (m_drop) begin
            m_drop = 1'b0;
          end else begin
            m_fifo.push_back({mem_word(m_req_addr), m_fetch_pc + 32'd4});
            m_fetch_pc = m_fetch_pc + 32'd4;
            m_pushes++;
          end
        end
        if (c_start) begin
          m_busy     = 1'b1;
          m_req_addr = m_fetch_pc;
          m_cnt      = $urandom_range(lat_max, lat_min);
        end
      end
    end
  end

  task automatic cycle();
    bit          d, j, s;
    logic [31:0] ja, q;
    @(posedge clk);
    #1;
    if (!rst_knob) model_reset();
    d = 1'b0;
    q = $urandom;
    if (m_busy) begin
      m_cnt--;
      if (m_cnt <= 0) begin
        d = 1'b1;
        q = mem_word(m_req_addr);
      end
    end else if (force_stray || (int'($urandom_range(0, 99)) < stray_pct)) begin
      d = 1'b1;
    end
    force_stray = 1'b0;
    j  = 1'b0;
    ja = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
    if (force_jump) begin
      j          = 1'b1;
      ja         = force_addr;
      force_jump = 1'b0;
    end else if (int'($urandom_range(0, 99)) < jump_pct) begin
      j = 1'b1;
    end
    s = int'($urandom_range(0, 99)) < stall_pct;
    if (jump_on_done && d) begin
      j            = 1'b1;
      ja           = force_addr;
      s            = 1'b0;
      jump_on_done = 1'b0;
      jod_fired    = 1'b1;
    end
    reset     = rst_knob;
    jump      = j;
    jump_addr = ja;
    stall     = s;
    bus_done  = d;
    bus_q     = q;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_knob = 1'b0;
    cycle();
    rst_knob = 1'b1;
  endtask

  task automatic wait_start(input string name, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      cycle();
      seen = bus_start;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_valid(input string name, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      cycle();
      seen = valid_out;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_size(input string name, input int n, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      cycle();
      seen = (m_fifo.size() == n);
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int n;
    int base;
    reset = 1'b0; jump = 1'b0; jump_addr = '0; stall = 1'b0; bus_done = 1'b0; bus_q = '0;
    model_reset();
    m_pushes = 0;
    run = 1'b1;

    // reset values
    do_reset();
    check("rst_bus_start", 32'(bus_start), 32'd0);
    check("rst_bus_addr", bus_addr, RESET_PC);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_instr", instr_out, 32'd0);
    check("rst_pc4", pc4_out, 32'd0);

    // fixed k=1 streaming
    cycle();
    check("t1_first_start", 32'(bus_start), 32'd1);
    check("t1_first_addr", bus_addr, 32'd0);
    cycle();
    check("t1_valid_k1", 32'(valid_out), 32'd0);
    cycle();
    check("t1_valid_k2", 32'(valid_out), 32'd1);
    check("t1_pc4", pc4_out, 32'd4);
    check("t1_instr", instr_out, 32'hA5A5A5A5);
    check("t1_next_addr", bus_addr, 32'd4);
    repeat (10) cycle();

    // fill under stall, single release
    stall_pct = 100;
    do_reset();
    n = 0;
    repeat (20) begin cycle(); if (bus_start) n++; end
    check("t2_starts_full", n, 4);
    check("t2_head", instr_out, 32'hA5A5A5A5);
    stall_pct = 0;
    cycle();
    stall_pct = 100;
    n = 0;
    repeat (6) begin cycle(); if (bus_start) n++; end
    check("t2_starts_after_pop", n, 1);
    check("t2_head_after_pop", instr_out, 32'hA5A5A5A1);

    // variable latency stream of 50 words
    lat_min = 1; lat_max = 7; stall_pct = 30;
    do_reset();
    base = m_pushes;
    for (int i = 0; i < 2000 && (m_pushes - base) < 50; i++) cycle();
    check("t3_words_streamed", 32'((m_pushes - base) >= 50), 32'd1);

    // jump while WAIT with two entries buffered
    lat_min = 1; lat_max = 1; stall_pct = 100;
    do_reset();
    wait_size("t4_fill", 2, 20);
    lat_min = 4; lat_max = 4;
    cycle();
    check("t4_issue", 32'(bus_start), 32'd1);
    force_jump = 1'b1; force_addr = 32'h100;
    cycle();
    cycle();
    check("t4_flushed", 32'(valid_out), 32'd0);
    stall_pct = 0;
    wait_start("t4_restart", 20);
    check("t4_target_addr", bus_addr, 32'h100);
    wait_valid("t4_valid", 20);
    check("t4_pc4", pc4_out, 32'h104);
    check("t4_instr", instr_out, 32'hA5A5A4A5);

    // jump coincident with bus_done and a pop
    lat_min = 3; lat_max = 3; stall_pct = 100;
    do_reset();
    wait_size("t5_fill", 2, 20);
    force_addr = 32'h300; jod_fired = 1'b0; jump_on_done = 1'b1;
    for (int i = 0; i < 20 && !jod_fired; i++) cycle();
    check("t5_fired", 32'(jod_fired), 32'd1);
    jump_on_done = 1'b0;
    cycle();
    check("t5_empty", 32'(valid_out), 32'd0);
    check("t5_start", 32'(bus_start), 32'd1);
    check("t5_addr", bus_addr, 32'h300);

    // second jump during discard
    stall_pct = 0; lat_min = 6; lat_max = 6;
    wait_start("t5b_issue", 20);
    force_jump = 1'b1; force_addr = 32'h400;
    cycle();
    force_jump = 1'b1; force_addr = 32'h200;
    cycle();
    wait_start("t5b_restart", 20);
    check("t5b_addr", bus_addr, 32'h200);

    // reset mid-WAIT, then stale completion
    lat_min = 5; lat_max = 5;
    do_reset();
    wait_start("t6_issue", 10);
    cycle();
    cycle();
    rst_knob = 1'b0;
    cycle();
    check("t6_rst_valid", 32'(valid_out), 32'd0);
    check("t6_rst_start", 32'(bus_start), 32'd0);
    check("t6_rst_addr", bus_addr, RESET_PC);
    rst_knob = 1'b1;
    force_stray = 1'b1;
    cycle();
    check("t6_start", 32'(bus_start), 32'd1);
    check("t6_addr", bus_addr, RESET_PC);
    wait_valid("t6_valid", 20);
    check("t6_pc4", pc4_out, RESET_PC + 32'd4);
    check("t6_instr", instr_out, mem_word(RESET_PC));

    // address wrap at top of memory
    lat_min = 1; lat_max = 1;
    do_reset();
    force_jump = 1'b1; force_addr = 32'hFFFFFFF8;
    cycle();
    wait_valid("wrap_valid0", 20);
    check("wrap_pc4_0", pc4_out, 32'hFFFFFFFC);
    check("wrap_instr_0", instr_out, 32'h5A5A5A5D);
    wait_valid("wrap_valid1", 20);
    check("wrap_pc4_1", pc4_out, 32'h00000000);
    check("wrap_instr_1", instr_out, 32'h5A5A5A59);

    // random traffic
    lat_min = 1; lat_max = 7; stall_pct = 40; jump_pct = 3; stray_pct = 5;
    do_reset();
    repeat (3000) cycle();
    jump_pct = 0; stray_pct = 0; stall_pct = 0;
    repeat (50) cycle();

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
Fetch-side front end of the B32P pipeline. It replaces the fixed-latency instruction memory with a variable-latency bus master and buffers fetched words in a small prefetch FIFO. Each FIFO entry holds an {instr, pc4} pair, which the unit presents to the FE→DE pipeline register. It also handles redirects from jumps resolved in MEM, including discard of in-flight fetches.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, ≥2.
RESET_PC, 32'd0, fetch address loaded on reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
jump  input  1  redirect request (jumpc_MEM | jumpr_MEM).
jump_addr  input  32  redirect target byte address.
stall  input  1  consumer hold; when 1, the FIFO head is not consumed.
bus_start  output  1  one-cycle request strobe to instruction bus.
bus_addr  output  32  fetch byte address; valid while bus_start=1 and held through WAIT.
bus_q  input  32  instruction word; valid when bus_done=1.
bus_done  input  1  one-cycle completion strobe.
instr_out  output  32  FIFO head instruction; 0 when empty.
pc4_out  output  32  FIFO head address+4; 0 when empty.
valid_out  output  1  FIFO non-empty.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - fetch_pc=RESET_PC, state=IDLE, FIFO count/pointers=0, discard=0.
  - bus_start=0, bus_addr=RESET_PC, valid_out=0, instr_out=0, pc4_out=0.
- Only one bus request is outstanding at a time. States:
  - IDLE: if !jump and count<DEPTH, assert bus_start=1 for this cycle with bus_addr=fetch_pc, then go to WAIT. Otherwise bus_start=0.
  - WAIT: bus_start=0 and bus_addr held. On bus_done:
    - If discard=0, push {bus_q, fetch_pc+4} and set fetch_pc+=4.
    - If discard=1, drop the word, leave fetch_pc unchanged, and clear discard.
    - In both cases go to IDLE.
- Latency: bus_start at cycle t and bus_done at cycle t+k gives valid_out=1 at t+k+1 (if FIFO was empty); k≥1. The next bus_start is no earlier than t+k+1.
- Pop: when valid_out=1 and stall=0, the head is consumed at the clock edge.
  - Push and pop may occur in the same cycle; count is then unchanged.
  - A push is accepted when full only if a pop occurs in the same cycle. The issue rule (count<DEPTH at issue) guarantees this case never needs to drop data.
- Outputs are combinational from the FIFO head and are 0 when empty.
- Pointers wrap modulo DEPTH. fetch_pc and pc4 wrap modulo 2^32 (0xFFFFFFFC+4=0).
- jump=1 (highest priority; overrides push, pop and issue in that cycle):
  - FIFO is flushed (count=0, pointers=0) and fetch_pc=jump_addr at the edge.
  - If state=WAIT and bus_done=0: discard=1 and the unit stays in WAIT.
  - If state=WAIT and bus_done=1 in the same cycle: the returned word is dropped and the unit goes to IDLE with discard=0.
  - In IDLE, no bus_start is issued during the jump cycle. The first fetch of the target is issued the following cycle.
- Repeated jumps while discard=1: fetch_pc is updated to the latest target and discard stays 1.
- bus_done while IDLE (for example, a stale completion after reset) is ignored.
- jump_addr is used unmodified; alignment is the producer's responsibility.

Test Plan:
1. Reset release, bus with fixed k=1 latency, stall=0 → bus_addr sequence 0,4,8,…; valid_out rises 2 cycles after the first bus_start; pc4_out=4,8,12 on successive valid cycles.
2. DEPTH=4, stall=1 held, k=1 → exactly 4 bus_start pulses, then none; count=4 and head instr unchanged. Release stall for 1 cycle → one pop, then one new bus_start.
3. Variable latency k=1..7 (random), 50 words preloaded mem[a]=a^32'hA5A5A5A5 → instr_out/pc4_out stream matches in order with no gaps or duplicates.
4. jump to 0x100 while WAIT (bus_done 3 cycles later, FIFO holding 2 entries) → valid_out=0 the next cycle; the late word is dropped; the next bus_addr=0x100; the first valid pc4_out=0x104.
5. jump coincident with bus_done, and simultaneously with a pop → no push, FIFO empty, next bus_start at jump_addr. Second jump to 0x200 during discard → first fetch is 0x200.
6. Assert reset (low) mid-WAIT, release, then a stale bus_done → all outputs at reset values, the stale word ignored, and the next bus_addr=RESET_PC.
